ping_responder: RTL and testbench

- Far-end transponder for the phase-ping ranging link.
- Qualifies an incoming RF burst from the digitizer strobe path, then fires a single transmit strobe a fixed, deterministic delay after the burst's first strobe.
- The initiator's begin-counter therefore measures 2×flight + DELAY.
- Sits between digitizer/strobe detector and the tx module; status counters go to hex_dump.

---
 rtl/ping_responder.sv | 135 +++++++++++++
 tb/tb_ping_responder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ping_responder.sv
`timescale 1ns/1ps
// Far-end transponder for the phase-ping ranging link: qualifies an RF burst
// and replies with one tx strobe exactly DELAY cycles after its first strobe.
module ping_responder #(
    parameter int CW       = 24,
    parameter int WINDOW   = 64,
    parameter int MIN_HITS = 4,
    parameter int DELAY    = 2048,
    parameter int HOLDOFF  = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clr,
    input  logic        rf_rx_stb,
    input  logic        tx_en,
    output logic        tx_stb,
    output logic        busy,
    output logic [2:0]  state,
    output logic [15:0] ping_cnt,
    output logic [15:0] miss_cnt,
    output logic [7:0]  last_hits
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_WAIT    = 3'd2,
        S_FIRE    = 3'd3,
        S_HOLD    = 3'd4
    } state_t;

    localparam logic [CW-1:0] WIN_T  = CW'(WINDOW);
    localparam logic [CW-1:0] FIRE_T = CW'(DELAY - 1);
    localparam logic [CW-1:0] HOLD_T = CW'(HOLDOFF - 1);
    localparam logic [7:0]    MIN_T  = 8'(MIN_HITS);

    state_t        cur;
    logic [CW-1:0] timer;
    logic [7:0]    hits;
    logic [CW-1:0] timer_inc;
    logic [7:0]    hits_fin;

    // Both the timer and the hit count saturate rather than wrap.
    assign timer_inc = (&timer) ? timer : timer + CW'(1);
    assign hits_fin  = !rf_rx_stb ? hits : ((&hits) ? hits : hits + 8'd1);
    assign state     = cur;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur       <= S_IDLE;
            busy      <= 1'b0;
            tx_stb    <= 1'b0;
            timer     <= '0;
            hits      <= '0;
            ping_cnt  <= '0;
            miss_cnt  <= '0;
            last_hits <= '0;
        end else begin
            tx_stb <= 1'b0;
            if (!en) begin
                cur   <= S_IDLE;
                busy  <= 1'b0;
                timer <= '0;
                hits  <= '0;
                // A reply already committed in FIRE is still sent and counted.
                if (cur == S_FIRE) begin
                    tx_stb   <= 1'b1;
                    ping_cnt <= ping_cnt + 16'd1;
                end
            end else begin
                case (cur)
                    S_IDLE: begin
                        if (!tx_en && rf_rx_stb) begin
                            cur   <= S_COLLECT;
                            busy  <= 1'b1;
                            timer <= CW'(1);
                            hits  <= 8'd1;
                        end
                    end
                    S_COLLECT: begin
                        hits  <= hits_fin;
                        timer <= timer_inc;
                        if (timer == WIN_T) begin
                            last_hits <= hits_fin;
                            if (hits_fin >= MIN_T) begin
                                cur <= S_WAIT;
                            end else begin
                                cur      <= S_IDLE;
                                busy     <= 1'b0;
                                timer    <= '0;
                                hits     <= '0;
                                miss_cnt <= miss_cnt + 16'd1;
                            end
                        end
                    end
                    S_WAIT: begin
                        timer <= timer_inc;
                        if (timer == FIRE_T) cur <= S_FIRE;
                    end
                    S_FIRE: begin
                        tx_stb   <= 1'b1;
                        ping_cnt <= ping_cnt + 16'd1;
                        timer    <= '0;
                        cur      <= S_HOLD;
                    end
                    S_HOLD: begin
                        if (timer >= HOLD_T && !tx_en) begin
                            cur   <= S_IDLE;
                            busy  <= 1'b0;
                            timer <= '0;
                            hits  <= '0;
                        end else begin
                            timer <= timer_inc;
                        end
                    end
                    default: begin
                        cur   <= S_IDLE;
                        busy  <= 1'b0;
                        timer <= '0;
                        hits  <= '0;
                    end
                endcase
            end
            // NOTE: the last non-blocking assignment in a block wins, so clr
            // placed here overrides any counter increment on the same edge.
            if (clr) begin
                ping_cnt  <= '0;
                miss_cnt  <= '0;
                last_hits <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ping_responder.sv
`timescale 1ns/1ps
// Scoreboard bench for ping_responder: expected replies are queued when a burst
// is issued and matched by a monitor whenever tx_stb appears.
module tb_ping_responder;

    localparam int DELAY   = 2048;
    localparam int WINDOW  = 64;
    localparam int HOLDOFF = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b1;
    logic        clr = 1'b0;
    logic        rf_rx_stb = 1'b0;
    logic        tx_en = 1'b0;
    logic        tx_stb, busy;
    logic [2:0]  state;
    logic [15:0] ping_cnt, miss_cnt;
    logic [7:0]  last_hits;

    // Second instance with a long window, used only for hit saturation.
    logic        rf2 = 1'b0;
    logic        tx_stb2, busy2;
    logic [2:0]  state2;
    logic [15:0] ping_cnt2, miss_cnt2;
    logic [7:0]  last_hits2;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cyc;
        logic [15:0] ping;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    ping_responder dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .rf_rx_stb(rf_rx_stb),
        .tx_en(tx_en), .tx_stb(tx_stb), .busy(busy), .state(state),
        .ping_cnt(ping_cnt), .miss_cnt(miss_cnt), .last_hits(last_hits)
    );

    ping_responder #(.WINDOW(300), .MIN_HITS(4), .DELAY(400), .HOLDOFF(8)) dut2 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .rf_rx_stb(rf2),
        .tx_en(tx_en), .tx_stb(tx_stb2), .busy(busy2), .state(state2),
        .ping_cnt(ping_cnt2), .miss_cnt(miss_cnt2), .last_hits(last_hits2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) step(1);
    endtask

    // Strobe sampled by the clock edge numbered e.
    task automatic stb_at(input int e);
        wait_cyc(e - 1);
        rf_rx_stb = 1'b1;
        step(1);
        rf_rx_stb = 1'b0;
    endtask

    task automatic valid_burst(input int t);
        for (int i = 0; i < 8; i++) stb_at(t + 4 * i);
    endtask

    task automatic expect_reply(input int c, input logic [15:0] p);
        exp_t e;
        e.cyc  = c;
        e.ping = p;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (tx_stb) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tx_stb: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("tx_stb_cycle", cyc, mon_e.cyc);
                check("ping_cnt_at_tx", ping_cnt, mon_e.ping);
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        // Reset held with strobes toggling.
        for (int i = 0; i < 6; i++) begin
            rf_rx_stb = i[0];
            step(1);
        end
        rf_rx_stb = 1'b0;
        check("rst_tx_stb", tx_stb, 0);
        check("rst_state", state, 0);
        check("rst_busy", busy, 0);
        check("rst_ping", ping_cnt, 0);
        check("rst_miss", miss_cnt, 0);
        check("rst_last_hits", last_hits, 0);
        rst = 1'b1;
        step(3);
        check("post_rst_state", state, 0);

        // Valid ping.
        t = cyc + 2;
        expect_reply(t + DELAY, 16'd1);
        valid_burst(t);
        wait_cyc(t + WINDOW);
        check("valid_state_wait", state, 2);
        check("valid_last_hits", last_hits, 8);
        check("valid_miss", miss_cnt, 0);
        check("valid_busy", busy, 1);
        wait_cyc(t + DELAY - 1);
        check("valid_state_fire", state, 3);
        wait_cyc(t + DELAY + HOLDOFF - 1);
        check("valid_state_hold", state, 4);
        wait_cyc(t + DELAY + HOLDOFF);
        check("valid_state_idle", state, 0);
        check("valid_busy_idle", busy, 0);
        check("valid_ping", ping_cnt, 1);

        // Weak burst, tx_en masking in IDLE, then a new COLLECT.
        t = cyc + 2;
        stb_at(t);
        stb_at(t + 10);
        wait_cyc(t + WINDOW - 1);
        check("weak_collect", state, 1);
        wait_cyc(t + WINDOW);
        check("weak_idle", state, 0);
        check("weak_miss", miss_cnt, 1);
        check("weak_last_hits", last_hits, 2);
        tx_en = 1'b1;
        stb_at(t + 80);
        check("txen_masks_idle", state, 0);
        tx_en = 1'b0;
        stb_at(t + 100);
        check("new_collect", state, 1);
        wait_cyc(t + 100 + WINDOW);
        check("single_miss_idle", state, 0);
        check("single_miss_cnt", miss_cnt, 2);
        check("single_last_hits", last_hits, 1);

        // Echo rejection in HOLD.
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        check("clr_ping", ping_cnt, 0);
        check("clr_miss", miss_cnt, 0);
        check("clr_last_hits", last_hits, 0);
        t = cyc + 2;
        expect_reply(t + DELAY, 16'd1);
        valid_burst(t);
        for (int i = 0; i < 8; i++) stb_at(t + 2100 + 4 * i);
        wait_cyc(t + 2200);
        check("echo_still_hold", state, 4);
        expect_reply(t + 6300 + DELAY, 16'd2);
        valid_burst(t + 6300);
        wait_cyc(t + 6300 + DELAY + HOLDOFF);
        check("echo_idle", state, 0);
        check("echo_ping", ping_cnt, 2);

        // Abort with en low.
        t = cyc + 2;
        valid_burst(t);
        wait_cyc(t + 999);
        en = 1'b0;
        step(1);
        check("abort_state", state, 0);
        check("abort_busy", busy, 0);
        en = 1'b1;
        wait_cyc(t + 2100);
        check("abort_ping", ping_cnt, 2);
        check("abort_idle", state, 0);

        // Abort with asynchronous reset mid-cycle.
        t = cyc + 2;
        valid_burst(t);
        wait_cyc(t + 1499);
        #2 rst = 1'b0;
        #1;
        check("arst_state", state, 0);
        check("arst_busy", busy, 0);
        check("arst_tx_stb", tx_stb, 0);
        check("arst_ping", ping_cnt, 0);
        check("arst_miss", miss_cnt, 0);
        check("arst_last_hits", last_hits, 0);
        step(1);
        rst = 1'b1;
        wait_cyc(t + 2100);
        check("arst_idle", state, 0);
        check("arst_ping_after", ping_cnt, 0);

        // ping_cnt wrap; tx_en during WAIT and held past HOLDOFF.
        force dut.ping_cnt = 16'hFFFF;
        #1;
        release dut.ping_cnt;
        check("preload_ping", ping_cnt, 16'hFFFF);
        t = cyc + 2;
        expect_reply(t + DELAY, 16'h0000);
        valid_burst(t);
        wait_cyc(t + 1000);
        tx_en = 1'b1;
        wait_cyc(t + DELAY);
        check("wrap_ping", ping_cnt, 0);
        wait_cyc(t + DELAY + HOLDOFF + 49);
        check("txen_holds_hold", state, 4);
        tx_en = 1'b0;
        step(1);
        check("txen_release_idle", state, 0);

        // clr on the FIRE edge.
        t = cyc + 2;
        expect_reply(t + DELAY, 16'h0000);
        valid_burst(t);
        wait_cyc(t + DELAY - 1);
        check("clrfire_state", state, 3);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        check("clrfire_ping", ping_cnt, 0);
        check("clrfire_last_hits", last_hits, 0);
        check("clrfire_hold", state, 4);
        wait_cyc(t + DELAY + HOLDOFF);
        check("clrfire_idle", state, 0);

        // 300 strobes in a 300-cycle window saturate the hit count.
        t = cyc + 2;
        wait_cyc(t - 1);
        rf2 = 1'b1;
        step(300);
        rf2 = 1'b0;
        check("sat_pre_last_hits", last_hits2, 0);
        check("sat_pre_state", state2, 1);
        step(1);
        check("sat_last_hits", last_hits2, 255);
        check("sat_state", state2, 2);
        wait_cyc(t + 399);
        check("sat_tx_early", tx_stb2, 0);
        step(1);
        check("sat_tx", tx_stb2, 1);
        check("sat_ping", ping_cnt2, 1);
        check("sat_miss", miss_cnt2, 0);
        wait_cyc(t + 410);
        check("sat_idle", state2, 0);
        check("sat_busy", busy2, 0);

        step(10);
        check("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
